// File: rtl/mux4way_arb.sv
// Four-channel valid/ready merge into one registered stream tagged with the source index.
// Define MUX4WAY_ARB_RR_EN for round-robin arbitration; otherwise fixed priority a > b > c > d.
module mux4way_arb #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             a_valid_i,
  input  logic             b_valid_i,
  input  logic             c_valid_i,
  input  logic             d_valid_i,
  output logic             a_ready_o,
  output logic             b_ready_o,
  output logic             c_ready_o,
  output logic             d_ready_o,
  output logic [WIDTH-1:0] out_o,
  output logic [1:0]       sel_o,
  output logic             valid_o,
  input  logic             ready_i
);

  logic [3:0]       req;
  logic [1:0]       ptr;
  logic [1:0]       grant_idx;
  logic [1:0]       idx;
  logic             found;
  logic             load_en;
  logic             grant;
  logic [WIDTH-1:0] grant_word;

  assign req     = {d_valid_i, c_valid_i, b_valid_i, a_valid_i};
  assign load_en = !valid_o || ready_i;

  // Search requesters starting at ptr; with ptr fixed at 00 this is plain a > b > c > d priority.
  always_comb begin
    grant_idx = 2'b00;
    found     = 1'b0;
    idx       = 2'b00;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        grant_idx = idx;
        found     = 1'b1;
      end
    end
  end

  // Gated by reset so no source sees ready while the block is held in reset.
  assign grant     = found && load_en && rst_n_i;
  assign a_ready_o = grant && (grant_idx == 2'd0);
  assign b_ready_o = grant && (grant_idx == 2'd1);
  assign c_ready_o = grant && (grant_idx == 2'd2);
  assign d_ready_o = grant && (grant_idx == 2'd3);

  always_comb begin
    grant_word = a_i;
    case (grant_idx)
      2'd0:    grant_word = a_i;
      2'd1:    grant_word = b_i;
      2'd2:    grant_word = c_i;
      default: grant_word = d_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_o   <= '0;
      sel_o   <= 2'b00;
      valid_o <= 1'b0;
    end else if (load_en) begin
      valid_o <= grant;
      if (grant) begin
        out_o <= grant_word;
        sel_o <= grant_idx;
      end
    end
  end

`ifdef MUX4WAY_ARB_RR_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr <= 2'b00;
    end else if (grant) begin
      ptr <= grant_idx + 2'd1;
    end
  end
`else
  assign ptr = 2'b00;
`endif

endmodule
